// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU,
// the unified memory port and the datapath registers one state per cycle.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_5,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] result_src,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    EXEC_I,
    ALU_WB,
    BRANCH,
    JAL,
    JALR,
    JALR_LINK,
    LUI
  } state_t;

  state_t state;
  state_t next_state;

  // Only R-type may turn func3=000 into a subtract; I-type has no subi.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_sub);
    case (f3)
      3'b000:  alu_decode = is_sub ? ALU_SUB : ALU_ADD;
      3'b010:  alu_decode = ALU_SLT;
      3'b100:  alu_decode = ALU_XOR;
      3'b110:  alu_decode = ALU_OR;
      3'b111:  alu_decode = ALU_AND;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  branch_taken = z;
      3'b001:  branch_taken = ~z;
      3'b100:  branch_taken = n;
      3'b101:  branch_taken = ~n;
      default: branch_taken = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= next_state;
  end

  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    imm_src     = IMM_I;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_B;
    alu_control = ALU_ADD;
    result_src  = RES_ALUOUT;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          next_state = DECODE;
        end
      end

      // Branch target is precomputed here so BRANCH only has to compare.
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_SW:   imm_src = IMM_S;
          OP_B:    imm_src = IMM_B;
          OP_JAL:  imm_src = IMM_J;
          OP_LUI:  imm_src = IMM_U;
          default: imm_src = IMM_I;
        endcase
        case (opcode)
          OP_LW, OP_SW: next_state = MEM_ADR;
          OP_R:         next_state = EXEC_R;
          OP_I:         next_state = EXEC_I;
          OP_B:         next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          OP_JALR:      next_state = JALR;
          OP_LUI:       next_state = LUI;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
            next_state = FETCH;
          end
        endcase
      end

      MEM_ADR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        imm_src    = (opcode == OP_SW) ? IMM_S : IMM_I;
        next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) next_state = MEM_WB;
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_DATA;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = FETCH;
        end
      end

      EXEC_R: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_B;
        alu_control = alu_decode(func3, func7_5);
        next_state  = ALU_WB;
      end

      EXEC_I: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_control = alu_decode(func3, 1'b0);
        next_state  = ALU_WB;
      end

      ALU_WB: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_B;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pc_write    = branch_taken(func3, zero, neg);
        instr_done  = 1'b1;
        next_state  = FETCH;
      end

      // The jump and the link share a cycle: PC takes the old ALUOut while
      // the ALU overwrites ALUOut with the return address.
      JAL, JALR_LINK: begin
        pc_write   = 1'b1;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        next_state = ALU_WB;
      end

      JALR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        next_state = JALR_LINK;
      end

      LUI: begin
        reg_write  = 1'b1;
        imm_src    = IMM_U;
        result_src = RES_IMM;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      default: next_state = FETCH;
    endcase

    // The state register clears asynchronously, but FETCH alone would still
    // request memory, so every output is forced low while reset is held.
    if (!rst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      imm_src     = IMM_I;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_B;
      alu_control = ALU_ADD;
      result_src  = RES_ALUOUT;
      instr_done  = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected output vectors are queued
// as each instruction is set up, then popped and compared cycle by cycle.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       func7_5;
  logic       zero;
  logic       neg;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b;
  logic [2:0] alu_control;
  logic [1:0] result_src;
  logic       instr_done, illegal;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        rdy;
    logic        z;
    logic        n;
    logic [19:0] exp;
  } sb_t;

  sb_t sb[$];

  logic [19:0] dut_vec;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5),
    .zero(zero), .neg(neg), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .imm_src(imm_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .result_src(result_src), .instr_done(instr_done), .illegal(illegal)
  );

  assign dut_vec = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, imm_src,
                    alu_src_a, alu_src_b, alu_control, result_src, instr_done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic pcw, input logic adr, input logic mrd,
                                     input logic mwr, input logic irw, input logic rgw,
                                     input logic [2:0] imm, input logic [1:0] sa,
                                     input logic [1:0] sb_sel, input logic [2:0] alu,
                                     input logic [1:0] rs, input logic done, input logic ill);
    mk = {pcw, adr, mrd, mwr, irw, rgw, imm, sa, sb_sel, alu, rs, done, ill};
  endfunction

  function automatic logic [19:0] v_fetch_ok();
    v_fetch_ok = mk(1, 0, 1, 0, 1, 0, 3'd0, 2'd0, 2'd2, 3'd0, 2'd2, 0, 0);
  endfunction
  function automatic logic [19:0] v_fetch_wait();
    v_fetch_wait = mk(0, 0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0);
  endfunction
  function automatic logic [19:0] v_decode(input logic [2:0] imm);
    v_decode = mk(0, 0, 0, 0, 0, 0, imm, 2'd1, 2'd1, 3'd0, 2'd0, 0, 0);
  endfunction
  function automatic logic [19:0] v_alu_wb();
    v_alu_wb = mk(0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1, 0);
  endfunction
  function automatic logic [19:0] v_link();
    v_link = mk(1, 0, 0, 0, 0, 0, 3'd0, 2'd1, 2'd2, 3'd0, 2'd0, 0, 0);
  endfunction
  function automatic logic [19:0] v_branch(input logic taken);
    v_branch = mk(taken, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, 1, 0);
  endfunction

  task automatic push(input logic rdy, input logic z, input logic n, input logic [19:0] exp);
    sb_t e;
    e.rdy = rdy; e.z = z; e.n = n; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; func3 = f3; func7_5 = f7;
  endtask

  // Entered #1 after a rising edge; drains the queue one cycle per entry and
  // then checks the cycle in which instr_done first pulsed (0 = never).
  task automatic run_sb(input string name, input int exp_done_cycle);
    int cyc = 0;
    int done_at = 0;
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy; zero = e.z; neg = e.n;
      @(negedge clk);
      cyc++;
      total++;
      if (dut_vec !== e.exp) begin
        bad++;
        $display("[TB] FAIL %s cycle %0d: got %b want %b", name, cyc, dut_vec, e.exp);
      end
      if (instr_done === 1'b1 && done_at == 0) done_at = cyc;
      @(posedge clk);
      #1;
    end
    total++;
    if (done_at !== exp_done_cycle) begin
      bad++;
      $display("[TB] FAIL %s length: done at %0d want %0d", name, done_at, exp_done_cycle);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; neg = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    #3;
    total++;
    if (dut_vec !== 20'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %b want %b", dut_vec, 20'd0);
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    if (dut_vec !== v_fetch_wait()) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b want %b", dut_vec, v_fetch_wait());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_r_sub();
    set_instr(7'b0110011, 3'b000, 1'b1);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd0));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd0, 3'd1, 2'd0, 0, 0));
    push(1, 0, 0, v_alu_wb());
    run_sb("r_sub", 4);
  endtask

  task automatic test_i_type();
    set_instr(7'b0010011, 3'b000, 1'b1);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd0));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0));
    push(1, 0, 0, v_alu_wb());
    run_sb("addi_f7", 4);
    set_instr(7'b0010011, 3'b110, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd0));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 3'd3, 2'd0, 0, 0));
    push(1, 0, 0, v_alu_wb());
    run_sb("ori", 4);
  endtask

  task automatic test_lw_wait();
    set_instr(7'b0000011, 3'b010, 1'b0);
    push(0, 0, 0, v_fetch_wait());
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd0));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0));
    push(0, 0, 0, mk(0, 1, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    push(0, 0, 0, mk(0, 1, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    push(1, 0, 0, mk(0, 1, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 3'd0, 2'd1, 1, 0));
    run_sb("lw_wait", 8);
  endtask

  task automatic test_branches();
    logic [2:0] f3s [4] = '{3'b000, 3'b001, 3'b101, 3'b010};
    logic       zs  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       ns  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_instr(7'b1100011, f3s[i], 1'b0);
      push(1, 0, 0, v_fetch_ok());
      push(1, 0, 0, v_decode(3'd2));
      push(1, zs[i], ns[i], v_branch(tk[i]));
      run_sb($sformatf("branch_f3_%0d", f3s[i]), 3);
    end
  endtask

  task automatic test_jumps();
    set_instr(7'b1100111, 3'b000, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd0));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0));
    push(1, 0, 0, v_link());
    push(1, 0, 0, v_alu_wb());
    run_sb("jalr", 5);
    set_instr(7'b1101111, 3'b000, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd3));
    push(1, 0, 0, v_link());
    push(1, 0, 0, v_alu_wb());
    run_sb("jal", 4);
  endtask

  task automatic test_lui_sw();
    set_instr(7'b0110111, 3'b000, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd4));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 1, 3'd4, 2'd0, 2'd0, 3'd0, 2'd3, 1, 0));
    run_sb("lui", 3);
    set_instr(7'b0100011, 3'b010, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd1));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0));
    push(0, 0, 0, mk(0, 1, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    push(1, 0, 0, mk(0, 1, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 1, 0));
    run_sb("sw_wait", 5);
  endtask

  task automatic test_illegal();
    set_instr(7'b1110011, 3'b000, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd0, 2'd1, 2'd1, 3'd0, 2'd0, 1, 1));
    push(0, 0, 0, v_fetch_wait());
    run_sb("illegal", 2);
  endtask

  task automatic test_reset_mid_write();
    set_instr(7'b0100011, 3'b010, 1'b0);
    push(1, 0, 0, v_fetch_ok());
    push(1, 0, 0, v_decode(3'd1));
    push(1, 0, 0, mk(0, 0, 0, 0, 0, 0, 3'd1, 2'd2, 2'd1, 3'd0, 2'd0, 0, 0));
    push(0, 0, 0, mk(0, 1, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 3'd0, 2'd0, 0, 0));
    run_sb("sw_abort_pre", 0);
    mem_ready = 1'b0;
    #2;
    total++;
    if (mem_write !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sw_abort_held: mem_write got %b want 1", mem_write);
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    total++;
    if (dut_vec !== 20'd0) begin
      bad++;
      $display("[TB] FAIL sw_abort_reset: got %b want %b", dut_vec, 20'd0);
    end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    if (dut_vec !== v_fetch_wait()) begin
      bad++;
      $display("[TB] FAIL sw_abort_release: got %b want %b", dut_vec, v_fetch_wait());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_r_sub();
    test_i_type();
    test_lw_wait();
    test_branches();
    test_jumps();
    test_lui_sw();
    test_illegal();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
